// File: rtl/debounce_toggle_driver.sv
// Push-button synchronizer + debouncer emitting one t_out pulse per accepted press, with optional auto-repeat.
// Latency: press pulse DEBOUNCE_CYCLES+1 edges after btn_in is first captured; no backpressure (free-running pulse source).
module debounce_toggle_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic repeat_en,
    output logic t_out,
    output logic btn_level
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [REP_W-1:0] RD_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RP_LAST  = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_phase_q, rep_phase_d;
    logic             s1_q, btn_s_q;
    logic             t_out_q, t_out_d;
    logic             btn_level_q, btn_level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STABLE_LO;
            cnt_q       <= '0;
            rep_q       <= '0;
            rep_phase_q <= 1'b0;
            s1_q        <= 1'b0;
            btn_s_q     <= 1'b0;
            t_out_q     <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            rep_phase_q <= rep_phase_d;
            s1_q        <= btn_in;
            btn_s_q     <= s1_q;
            t_out_q     <= t_out_d;
            btn_level_q <= btn_level_d;
        end
    end

    // Any sample agreeing with the current level drops straight back to the stable state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LO: begin
                if (btn_s_q) begin
                    state_d = (DEBOUNCE_CYCLES == 1) ? STABLE_HI : WAIT_HI;
                    cnt_d   = (DEBOUNCE_CYCLES == 1) ? '0 : CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!btn_s_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!btn_s_q) begin
                    state_d = (DEBOUNCE_CYCLES == 1) ? STABLE_LO : WAIT_LO;
                    cnt_d   = (DEBOUNCE_CYCLES == 1) ? '0 : CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (btn_s_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // rep_phase_q selects between the initial delay and the steady repeat period.
    always_comb begin
        t_out_d     = 1'b0;
        btn_level_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);
        rep_d       = '0;
        rep_phase_d = 1'b0;
        if ((state_q == STABLE_LO || state_q == WAIT_HI) && state_d == STABLE_HI) begin
            t_out_d = 1'b1;
        end else if (state_q == STABLE_HI && state_d == STABLE_HI && repeat_en) begin
            if (rep_q == (rep_phase_q ? RP_LAST : RD_LAST)) begin
                t_out_d     = 1'b1;
                rep_phase_d = 1'b1;
            end else begin
                rep_d       = rep_q + REP_ONE;
                rep_phase_d = rep_phase_q;
            end
        end
    end

    assign t_out     = t_out_q;
    assign btn_level = btn_level_q;

endmodule

// File: tb/tb_debounce_toggle_driver.sv
// Bench for debounce_toggle_driver: vector table, directed corner sequences, random stimulus vs. a reference model.
`timescale 1ns/1ps
module tb_debounce_toggle_driver;

    localparam int D  = 4;
    localparam int RD = 16;
    localparam int RP = 8;
    localparam int NV = 30;

    logic clk, rst_n, btn_in, repeat_en;
    logic t_out, btn_level;
    logic q;

    debounce_toggle_driver #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .repeat_en(repeat_en),
        .t_out    (t_out),
        .btn_level(btn_level)
    );

    always #1 clk = ~clk;

    // Downstream T flip-flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else if (t_out) q <= ~q;
    end

    typedef struct {
        logic btn;
        logic exp_t;
        logic exp_l;
    } vec_t;
    vec_t tbl[NV];

    int n_cmp = 0;
    int n_bad = 0;
    int first, npulse, found;
    logic [11:0] bpat;
    logic [9:0]  rpat;

    // Reference model: debounced level = flips when the last D synchronized samples all disagree.
    logic rawq[$];
    logic seenq[$];
    logic m_lvl, m_prev, m_t;
    int   m_run;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic b, input logic r);
        btn_in    = b;
        repeat_en = r;
        @(posedge clk);
        #0.5;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        btn_in    = 1'b0;
        repeat_en = 1'b0;
        repeat (3) @(posedge clk);
        #0.5;
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        rawq.delete();
        seenq.delete();
        rawq.push_back(1'b0);
        rawq.push_back(1'b0);
        for (int i = 0; i < D; i++) seenq.push_back(1'b0);
        m_lvl  = 1'b0;
        m_prev = 1'b0;
        m_run  = 0;
        m_t    = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic r);
        logic s, all1, all0;
        s = rawq.pop_front();
        rawq.push_back(b);
        void'(seenq.pop_front());
        seenq.push_back(s);
        all1 = 1'b1;
        all0 = 1'b1;
        foreach (seenq[i]) begin
            if (seenq[i] != 1'b1) all1 = 1'b0;
            if (seenq[i] != 1'b0) all0 = 1'b0;
        end
        m_t = 1'b0;
        if (!m_lvl) begin
            if (all1) begin
                m_lvl = 1'b1;
                m_t   = 1'b1;
                m_run = 0;
            end
        end else if (all0) begin
            m_lvl = 1'b0;
            m_run = 0;
        end else if (s && m_prev && r) begin
            m_run++;
            m_t = (m_run >= RD) && (((m_run - RD) % RP) == 0);
        end else begin
            m_run = 0;
        end
        m_prev = s;
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;

        // Rows 0-7: 3-cycle glitch; rows 8-19: bounce then hold; rows 20-29: release with bounce.
        bpat = 12'b1011_0111_1111;
        rpat = 10'b0110_0000_00;
        for (int i = 0; i < NV; i++) begin
            if (i < 8)       tbl[i].btn = (i < 3);
            else if (i < 20) tbl[i].btn = bpat[11-(i-8)];
            else             tbl[i].btn = rpat[9-(i-20)];
            tbl[i].exp_t = (i == 18);
            tbl[i].exp_l = (i >= 18) && (i <= 27);
        end

        #0.3 rst_n = 1'b0;
        #0.2;
        check("reset_t_out", t_out, 0);
        check("reset_btn_level", btn_level, 0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].btn, 1'b0);
            check($sformatf("tbl%0d_t_out", i), t_out, tbl[i].exp_t);
            check($sformatf("tbl%0d_btn_level", i), btn_level, tbl[i].exp_l);
        end

        // Clean press: pulse on e5, exactly once, q toggles once.
        do_reset();
        first = -1;
        npulse = 0;
        for (int e = 0; e < 20; e++) begin
            step(1'b1, 1'b0);
            if (t_out) begin
                npulse++;
                if (first < 0) first = e;
            end
        end
        check("clean_press_edge", first, 5);
        check("clean_press_count", npulse, 1);
        check("clean_press_level", btn_level, 1);
        check("clean_press_q", q, 1);

        // Auto-repeat, with and without dropping repeat_en after P+30.
        for (int drop = 0; drop < 2; drop++) begin
            do_reset();
            found = 0;
            for (int k = 0; k < 20 && !found; k++) begin
                step(1'b1, 1'b1);
                if (t_out) found = 1;
            end
            check($sformatf("rep%0d_press_found", drop), found, 1);
            for (int off = 1; off <= 50; off++) begin
                logic exp_p;
                step(1'b1, (drop == 1 && off > 30) ? 1'b0 : 1'b1);
                exp_p = (off >= RD) && (((off - RD) % RP) == 0) && !(drop == 1 && off > 30);
                check($sformatf("rep%0d_P+%0d", drop, off), t_out, exp_p);
            end
        end

        // Async reset during the press pulse, then re-qualification.
        do_reset();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b1, 1'b0);
            if (t_out) found = 1;
        end
        check("rst_press_found", found, 1);
        rst_n = 1'b0;
        #0.2;
        check("rst_kill_t_out", t_out, 0);
        check("rst_kill_btn_level", btn_level, 0);
        repeat (3) @(posedge clk);
        #0.3;
        check("rst_hold_btn_level", btn_level, 0);
        rst_n = 1'b1;
        first = -1;
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            if (t_out && first < 0) first = e;
        end
        check("rst_repress_edge", first, 6);

        // Two presses: q goes 0 -> 1 -> 0.
        do_reset();
        npulse = 0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < 12; k++) begin
                step((ph % 2) == 0, 1'b0);
                if (t_out) npulse++;
            end
            if (ph == 0) check("two_q_after_press1", q, 1);
            if (ph == 1) check("two_q_after_release1", q, 1);
            if (ph == 2) check("two_q_after_press2", q, 0);
        end
        check("two_pulse_count", npulse, 2);

        // Random stimulus against the reference model.
        do_reset();
        model_reset();
        begin
            logic cur, ren;
            int   runleft;
            cur = 1'b0;
            ren = 1'b1;
            runleft = 0;
            for (int n = 0; n < 1500; n++) begin
                if (runleft == 0) begin
                    cur = ~cur;
                    runleft = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 6);
                end
                runleft--;
                if ($urandom_range(0, 63) == 0) ren = ~ren;
                model_step(cur, ren);
                step(cur, ren);
                check($sformatf("rand%0d_t_out", n), t_out, m_t);
                check($sformatf("rand%0d_btn_level", n), btn_level, m_lvl);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
